// File: rtl/link_mon_pkg.sv
// -----------------------------------------------------------------------------
// link_mon_pkg
// Shared definitions for the Aurora link monitor:
//   - link_state_t : per-lane monitor state
//   - RETRY_W      : width of the per-lane consecutive-request counter
//   - *_DEF        : default parameter values (100 MHz timing)
//   - retry_inc()  : saturating increment of the request counter
// -----------------------------------------------------------------------------
package link_mon_pkg;

    typedef enum logic [2:0] {
        WAIT_UP = 3'd0,
        UP      = 3'd1,
        LOSS    = 3'd2,
        REQ     = 3'd3,
        FAILED  = 3'd4
    } link_state_t;

    localparam int RETRY_W = 4;

    localparam int LANE_NUM_DEF   = 4;
    localparam int UP_TIMEOUT_DEF = 100000;  // 1 ms at 100 MHz
    localparam int DEBOUNCE_DEF   = 16;
    localparam int RST_PULSE_DEF  = 128;
    localparam int MAX_RETRY_DEF  = 7;

    // Counts requests without wrapping, so a lane that keeps failing reads 15.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
        return (cnt == {RETRY_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage : link_mon_pkg

// File: rtl/lane_link_fsm.sv
// -----------------------------------------------------------------------------
// lane_link_fsm
// Monitor for one Aurora lane: 2-flop synchronizer on channel_up, debounce,
// bring-up timeout and fixed-width reset request generation.
//
// Ports:
//   clk        : clock (clk_100m domain)
//   rst        : synchronous active-high reset
//   mon_en     : monitoring enable; low parks the lane in WAIT_UP
//   channel_up : asynchronous lane status from the Aurora core
//   rst_req    : registered reset request to the lane
//   lane_up    : lane is in UP or LOSS
//   lane_fail  : lane is in FAILED (tied 0 unless LINK_MON_RETRY_LIMIT_EN)
//   retry_cnt  : consecutive requests issued, saturating at 15
//
// Build option: LINK_MON_RETRY_LIMIT_EN enables the FAILED state after
// MAX_RETRY consecutive requests; without it the lane retries forever.
// -----------------------------------------------------------------------------
module lane_link_fsm
    import link_mon_pkg::*;
#(
    parameter int UP_TIMEOUT = UP_TIMEOUT_DEF,
    parameter int DEBOUNCE   = DEBOUNCE_DEF,
    parameter int RST_PULSE  = RST_PULSE_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mon_en,
    input  logic               channel_up,
    output logic               rst_req,
    output logic               lane_up,
    output logic               lane_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int TMR_W  = $clog2(UP_TIMEOUT + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int PCNT_W = $clog2(RST_PULSE + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(UP_TIMEOUT - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    // REQ lasts RST_PULSE+1 cycles: RST_PULSE with the request high, then one
    // idle cycle before WAIT_UP so back-to-back requests are clearly separated.
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RST_PULSE);

`ifdef LINK_MON_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic [1:0]         sync_q;
    logic               up_s;
    link_state_t        state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [DEB_W-1:0]   deb, deb_nxt;
    logic [PCNT_W-1:0]  pcnt, pcnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               at_limit;

    assign up_s     = sync_q[1];
    assign at_limit = LIMIT_EN && (retry_cnt == RETRY_W'(MAX_RETRY));
    assign lane_up  = (state == UP) || (state == LOSS);

`ifdef LINK_MON_RETRY_LIMIT_EN
    assign lane_fail = (state == FAILED);
`else
    assign lane_fail = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        deb_nxt   = deb;
        pcnt_nxt  = pcnt;
        retry_nxt = retry_cnt;

        if (!mon_en) begin
            // Park in WAIT_UP with timers cleared; the request count survives
            // so the history is still visible once monitoring resumes.
            state_nxt = (state == FAILED) ? FAILED : WAIT_UP;
            tmr_nxt   = '0;
            deb_nxt   = '0;
            pcnt_nxt  = '0;
        end else begin
            case (state)
                WAIT_UP: begin
                    // A debounced rise takes priority over a coincident timeout.
                    if (up_s && (deb == DEB_LAST)) begin
                        state_nxt = UP;
                        tmr_nxt   = '0;
                        deb_nxt   = '0;
                        retry_nxt = '0;
                    end else if (tmr == TMR_LAST) begin
                        state_nxt = REQ;
                        tmr_nxt   = '0;
                        deb_nxt   = '0;
                        pcnt_nxt  = '0;
                        retry_nxt = retry_inc(retry_cnt);
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                        deb_nxt = up_s ? deb + 1'b1 : '0;
                    end
                end
                UP: begin
                    if (!up_s) begin
                        state_nxt = LOSS;
                        deb_nxt   = '0;
                    end
                end
                LOSS: begin
                    if (up_s) begin
                        state_nxt = UP;
                        deb_nxt   = '0;
                    end else if (deb == DEB_LAST) begin
                        state_nxt = REQ;
                        deb_nxt   = '0;
                        pcnt_nxt  = '0;
                        retry_nxt = retry_inc(retry_cnt);
                    end else begin
                        deb_nxt = deb + 1'b1;
                    end
                end
                REQ: begin
                    if (pcnt == PCNT_LAST) begin
                        state_nxt = at_limit ? FAILED : WAIT_UP;
                        pcnt_nxt  = '0;
                        tmr_nxt   = '0;
                        deb_nxt   = '0;
                    end else begin
                        pcnt_nxt = pcnt + 1'b1;
                    end
                end
                FAILED: begin
                    state_nxt = FAILED;
                end
                default: begin
                    state_nxt = WAIT_UP;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state     <= WAIT_UP;
            tmr       <= '0;
            deb       <= '0;
            pcnt      <= '0;
            retry_cnt <= '0;
            rst_req   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], channel_up};
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            deb       <= deb_nxt;
            pcnt      <= pcnt_nxt;
            retry_cnt <= retry_nxt;
            // Registered from next-state so the request rises together with
            // the REQ state and skips the trailing idle cycle.
            rst_req   <= (state_nxt == REQ) && (pcnt_nxt != PCNT_LAST);
        end
    end

endmodule : lane_link_fsm

// File: rtl/aurora_link_monitor.sv
// -----------------------------------------------------------------------------
// aurora_link_monitor
// Watches channel_up of each Aurora lane and requests a per-lane re-reset when
// a lane fails to come up in time or drops out. link_rst_req_o is ORed into
// the per-lane Aurora reset conditions by the reset generator.
//
// Ports:
//   clk_100m       : the only clock
//   rst_100m       : synchronous active-high reset
//   mon_en_i       : monitoring enable (synced hmc7044_config_ok)
//   channel_up_i   : per-lane asynchronous channel_up from the Aurora cores
//   link_rst_req_o : per-lane registered reset request
//   lane_up_o      : per-lane up indication (UP or LOSS)
//   all_up_o       : registered AND of lane_up_o
//   lane_fail_o    : per-lane FAILED indication
//   retry_cnt_o    : 4 bits per lane, lane i at [4*i +: 4]
//
// Build option: LINK_MON_RETRY_LIMIT_EN enables the per-lane retry limit
// (MAX_RETRY) and the FAILED state; otherwise lane_fail_o is always 0.
// -----------------------------------------------------------------------------
module aurora_link_monitor
    import link_mon_pkg::*;
#(
    parameter int LANE_NUM   = LANE_NUM_DEF,
    parameter int UP_TIMEOUT = UP_TIMEOUT_DEF,
    parameter int DEBOUNCE   = DEBOUNCE_DEF,
    parameter int RST_PULSE  = RST_PULSE_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic                        clk_100m,
    input  logic                        rst_100m,
    input  logic                        mon_en_i,
    input  logic [LANE_NUM-1:0]         channel_up_i,
    output logic [LANE_NUM-1:0]         link_rst_req_o,
    output logic [LANE_NUM-1:0]         lane_up_o,
    output logic                        all_up_o,
    output logic [LANE_NUM-1:0]         lane_fail_o,
    output logic [RETRY_W*LANE_NUM-1:0] retry_cnt_o
);

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        lane_link_fsm #(
            .UP_TIMEOUT (UP_TIMEOUT),
            .DEBOUNCE   (DEBOUNCE),
            .RST_PULSE  (RST_PULSE),
            .MAX_RETRY  (MAX_RETRY)
        ) u_lane (
            .clk        (clk_100m),
            .rst        (rst_100m),
            .mon_en     (mon_en_i),
            .channel_up (channel_up_i[i]),
            .rst_req    (link_rst_req_o[i]),
            .lane_up    (lane_up_o[i]),
            .lane_fail  (lane_fail_o[i]),
            .retry_cnt  (retry_cnt_o[RETRY_W*i +: RETRY_W])
        );
    end

    always_ff @(posedge clk_100m) begin
        if (rst_100m) begin
            all_up_o <= 1'b0;
        end else begin
            all_up_o <= &lane_up_o;
        end
    end

endmodule : aurora_link_monitor

// File: tb/tb_aurora_link_monitor.sv
// -----------------------------------------------------------------------------
// tb_aurora_link_monitor
// Directed bench for aurora_link_monitor with UP_TIMEOUT=200, DEBOUNCE=4,
// RST_PULSE=8, MAX_RETRY=3. Cycle N is the interval after the Nth rising edge
// counted from the last reset edge; inputs driven in cycle N are first sampled
// at edge N+1. Outputs are checked and inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_aurora_link_monitor;

    localparam int LANES = 4;

    logic        clk_100m     = 1'b0;
    logic        rst_100m     = 1'b1;
    logic        mon_en_i     = 1'b1;
    logic [3:0]  channel_up_i = 4'h0;
    logic [3:0]  link_rst_req_o;
    logic [3:0]  lane_up_o;
    logic        all_up_o;
    logic [3:0]  lane_fail_o;
    logic [15:0] retry_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int now      = 0;

    always #5 clk_100m = ~clk_100m;

    aurora_link_monitor #(
        .LANE_NUM   (LANES),
        .UP_TIMEOUT (200),
        .DEBOUNCE   (4),
        .RST_PULSE  (8),
        .MAX_RETRY  (3)
    ) dut (
        .clk_100m       (clk_100m),
        .rst_100m       (rst_100m),
        .mon_en_i       (mon_en_i),
        .channel_up_i   (channel_up_i),
        .link_rst_req_o (link_rst_req_o),
        .lane_up_o      (lane_up_o),
        .all_up_o       (all_up_o),
        .lane_fail_o    (lane_fail_o),
        .retry_cnt_o    (retry_cnt_o)
    );

    typedef struct {
        int          cyc;
        logic        rst;
        logic        en;
        logic [3:0]  ch;
        logic [3:0]  e_req;
        logic [3:0]  e_up;
        logic        e_all;
        logic [15:0] e_retry;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, now, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        check(name, {28'd0, act}, {28'd0, exp});
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, {16'd0, act}, {16'd0, exp});
    endtask

    task automatic advance();
        @(negedge clk_100m);
        now++;
    endtask

    task automatic wait_until(input int t);
        while (now < t) advance();
    endtask

    // Holds reset for three edges; returns in cycle 0 with reset still high.
    task automatic do_reset();
        rst_100m = 1'b1;
        repeat (3) advance();
        now = 0;
    endtask

    task automatic check_vec(input vec_t v);
        check4 ({v.name, "_req"},   link_rst_req_o, v.e_req);
        check4 ({v.name, "_up"},    lane_up_o,      v.e_up);
        check4 ({v.name, "_all"},   {3'b000, all_up_o}, {3'b000, v.e_all});
        check16({v.name, "_retry"}, retry_cnt_o,    v.e_retry);
        check4 ({v.name, "_fail"},  lane_fail_o,    4'h0);
    endtask

    initial begin
        // cyc, rst, en, ch (driven after the check), req, up, all, retry, name
        tbl.push_back('{0,  1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, "reset"});
        tbl.push_back('{10, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 16'h0000, "pre_rise"});
        tbl.push_back('{15, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 16'h0000, "deb_busy"});
        tbl.push_back('{16, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0000, "lane_up_rise"});
        tbl.push_back('{17, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 16'h0000, "all_up_lag"});
        tbl.push_back('{30, 1'b0, 1'b1, 4'hB, 4'h0, 4'hF, 1'b1, 16'h0000, "glitch_start"});
        tbl.push_back('{33, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 16'h0000, "glitch_loss"});
        tbl.push_back('{36, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 16'h0000, "glitch_back"});
        tbl.push_back('{45, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 1'b1, 16'h0000, "glitch_settled"});
        tbl.push_back('{50, 1'b0, 1'b1, 4'hD, 4'h0, 4'hF, 1'b1, 16'h0000, "loss_start"});
        tbl.push_back('{56, 1'b0, 1'b1, 4'hD, 4'h0, 4'hF, 1'b1, 16'h0000, "loss_deb"});
        tbl.push_back('{57, 1'b0, 1'b1, 4'hD, 4'h2, 4'hD, 1'b1, 16'h0010, "loss_req_rise"});
        tbl.push_back('{58, 1'b0, 1'b1, 4'hD, 4'h2, 4'hD, 1'b0, 16'h0010, "all_up_drop"});
        tbl.push_back('{64, 1'b0, 1'b1, 4'hD, 4'h2, 4'hD, 1'b0, 16'h0010, "req_last"});
        tbl.push_back('{65, 1'b0, 1'b1, 4'hD, 4'h0, 4'hD, 1'b0, 16'h0010, "req_fall"});

        // Bring-up, glitch rejection and link loss on a single timeline.
        do_reset();
        foreach (tbl[i]) begin
            wait_until(tbl[i].cyc);
            check_vec(tbl[i]);
            rst_100m     = tbl[i].rst;
            mon_en_i     = tbl[i].en;
            channel_up_i = tbl[i].ch;
        end

        // Timeout: lane 0 never comes up, lanes 1..3 are up. Requests start at
        // 200 + 209*k (8 high cycles + 1 idle + 200 waiting).
        do_reset();
        check16("rst_retry_zero", retry_cnt_o, 16'h0000);
        check4 ("rst_req_zero",   link_rst_req_o, 4'h0);
        rst_100m     = 1'b0;
        channel_up_i = 4'hE;
        for (int k = 0; k < 3; k++) begin
            int start;
            start = 200 + 209 * k;
            wait_until(start - 1);
            check4 ("tmo_pre",   link_rst_req_o, 4'h0);
            check4 ("tmo_up",    lane_up_o,      4'hE);
            wait_until(start);
            check4 ("tmo_rise",  link_rst_req_o, 4'h1);
            check16("tmo_retry", retry_cnt_o,    16'(k + 1));
            wait_until(start + 7);
            check4 ("tmo_last",  link_rst_req_o, 4'h1);
            wait_until(start + 8);
            check4 ("tmo_fall",  link_rst_req_o, 4'h0);
        end
`ifdef LINK_MON_RETRY_LIMIT_EN
        wait_until(630);
        check4 ("limit_fail",    lane_fail_o,    4'h1);
        wait_until(827);
        check4 ("limit_no_req",  link_rst_req_o, 4'h0);
        check16("limit_retry",   retry_cnt_o,    16'h0003);
        check4 ("limit_fail_hold", lane_fail_o,  4'h1);
`else
        wait_until(826);
        check4 ("retry4_pre",    link_rst_req_o, 4'h0);
        wait_until(827);
        check4 ("retry4_rise",   link_rst_req_o, 4'h1);
        check16("retry4_cnt",    retry_cnt_o,    16'h0004);
        check4 ("no_fail",       lane_fail_o,    4'h0);
`endif

        // Enable drop and reset in the middle of a request.
        do_reset();
        check16("rst2_retry_zero", retry_cnt_o, 16'h0000);
        check4 ("rst2_fail_zero",  lane_fail_o, 4'h0);
        rst_100m     = 1'b0;
        channel_up_i = 4'hE;
        wait_until(203);
        check4 ("en_mid_req",  link_rst_req_o, 4'h1);
        mon_en_i = 1'b0;
        wait_until(204);
        check4 ("en_req_drop", link_rst_req_o, 4'h0);
        check4 ("en_up_drop",  lane_up_o,      4'h0);
        check16("en_hold_retry", retry_cnt_o,  16'h0001);
        wait_until(210);
        mon_en_i = 1'b1;
        wait_until(213);
        check4 ("en_deb_busy", lane_up_o,      4'h0);
        wait_until(214);
        check4 ("en_reup",     lane_up_o,      4'hE);
        wait_until(409);
        check4 ("en_tmo_pre",  link_rst_req_o, 4'h0);
        wait_until(410);
        check4 ("en_tmo_rise", link_rst_req_o, 4'h1);
        check16("en_tmo_retry", retry_cnt_o,   16'h0002);
        wait_until(413);
        rst_100m = 1'b1;
        wait_until(414);
        check4 ("rst_req_drop", link_rst_req_o, 4'h0);
        check16("rst_retry_clr", retry_cnt_o,   16'h0000);
        check4 ("rst_up_clr",   lane_up_o,      4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_aurora_link_monitor
